// File: rtl/index_queue_reader_pkg.sv
// Shared constants and FSM state encoding for the index queue reader.
package index_queue_reader_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned INPUT_LAYER_NODES = 784;
  localparam int unsigned QUEUE_MAX_SIZE    = INPUT_LAYER_NODES;

  typedef enum logic [2:0] {
    IQR_IDLE    = 3'd0,
    IQR_CHECK   = 3'd1,
    IQR_DEQ_HI  = 3'd2,
    IQR_DEQ_LO  = 3'd3,
    IQR_CAPTURE = 3'd4,
    IQR_OUTPUT  = 3'd5,
    IQR_DONE    = 3'd6
  } iqr_state_t;

endpackage

// File: rtl/index_queue_reader_output_stage.sv
// Holding register for the delivered index with a valid/ready handshake.
module index_output_stage #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             accept_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign accept_o = valid_q & ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (accept_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/index_queue_reader.sv
// Drains the active-pixel index queue with the two-edge dequeue protocol.
// Optional drain guard enabled by defining INDEX_QUEUE_LIMIT_EN (adds limitHit).
module index_queue_reader
  import index_queue_reader_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   queueEmpty,
  input  logic [INDEX_WIDTH-1:0] queueIndex,
  output logic                   dequeue,
  output logic [INDEX_WIDTH-1:0] idxOut,
  output logic                   idxValid,
  input  logic                   idxReady,
  output logic [INDEX_WIDTH-1:0] popCount,
  output logic                   busy,
  output logic                   done
`ifdef INDEX_QUEUE_LIMIT_EN
  ,
  output logic                   limitHit
`endif
);

  iqr_state_t             state_q, state_d;
  logic [INDEX_WIDTH-1:0] pop_q, pop_d;
  logic                   deq_q;
  logic                   done_q;
  logic                   accept;

`ifdef INDEX_QUEUE_LIMIT_EN
  localparam logic [INDEX_WIDTH-1:0] POP_LIMIT = INDEX_WIDTH'(QUEUE_MAX_SIZE);
  logic limit_q, limit_d;
`endif

  always_comb begin
    state_d = state_q;
    pop_d   = pop_q;
`ifdef INDEX_QUEUE_LIMIT_EN
    limit_d = limit_q;
`endif
    case (state_q)
      IQR_IDLE, IQR_DONE: begin
        if (start) begin
          state_d = IQR_CHECK;
          pop_d   = '0;
`ifdef INDEX_QUEUE_LIMIT_EN
          limit_d = FALSE;
`endif
        end
      end
      IQR_CHECK: begin
`ifdef INDEX_QUEUE_LIMIT_EN
        if (pop_q == POP_LIMIT) begin
          state_d = IQR_DONE;
          limit_d = TRUE;
        end else
`endif
        if (queueEmpty) state_d = IQR_DONE;
        else            state_d = IQR_DEQ_HI;
      end
      IQR_DEQ_HI:  state_d = IQR_DEQ_LO;
      IQR_DEQ_LO:  state_d = IQR_CAPTURE;
      IQR_CAPTURE: state_d = IQR_OUTPUT;
      IQR_OUTPUT: begin
        if (accept) begin
          pop_d   = pop_q + 1'b1;
          state_d = IQR_CHECK;
        end
      end
      default: state_d = IQR_IDLE;
    endcase
  end

  // dequeue and done are registered from the next state so they leave the
  // flop glitch-free yet stay aligned with the state they belong to.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IQR_IDLE;
      pop_q   <= '0;
      deq_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      deq_q   <= (state_d == IQR_DEQ_HI);
      done_q  <= (state_d == IQR_DONE);
    end
  end

`ifdef INDEX_QUEUE_LIMIT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) limit_q <= 1'b0;
    else         limit_q <= limit_d;
  end
  assign limitHit = limit_q;
`endif

  index_output_stage #(
    .WIDTH (INDEX_WIDTH)
  ) u_output_stage (
    .clk      (clk),
    .rst_n    (resetN),
    .load_i   (state_q == IQR_CAPTURE),
    .data_i   (queueIndex),
    .ready_i  (idxReady),
    .data_o   (idxOut),
    .valid_o  (idxValid),
    .accept_o (accept)
  );

  assign dequeue  = deq_q;
  assign done     = done_q;
  assign popCount = pop_q;
  assign busy     = (state_q != IQR_IDLE) && (state_q != IQR_DONE);

endmodule

// File: tb/tb_index_queue_reader.sv
// Directed self-checking bench for index_queue_reader with a two-edge queue model.
module tb_index_queue_reader;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         resetN;
  logic         start;
  logic         queueEmpty;
  logic [W-1:0] queueIndex;
  logic         dequeue;
  logic [W-1:0] idxOut;
  logic         idxValid;
  logic         idxReady;
  logic [W-1:0] popCount;
  logic         busy;
  logic         done;
`ifdef INDEX_QUEUE_LIMIT_EN
  logic         limitHit;
`endif

  index_queue_reader #(.INDEX_WIDTH(W)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .queueEmpty (queueEmpty),
    .queueIndex (queueIndex),
    .dequeue    (dequeue),
    .idxOut     (idxOut),
    .idxValid   (idxValid),
    .idxReady   (idxReady),
    .popCount   (popCount),
    .busy       (busy),
    .done       (done)
`ifdef INDEX_QUEUE_LIMIT_EN
    ,
    .limitHit   (limitHit)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Queue model: index latched on rising dequeue, front advances on falling dequeue.
  logic [W-1:0] mem [0:1023];
  int unsigned  q_rd = 0;
  int unsigned  q_cnt = 0;
  int unsigned  deq_count = 0;
  logic         stuck = 1'b0;
  logic [W-1:0] seen [$];

  assign queueEmpty = (q_rd >= q_cnt) && !stuck;

  always @(posedge dequeue) begin
    queueIndex = mem[q_rd % 1024];
    deq_count++;
  end
  always @(negedge dequeue) q_rd++;

  always @(negedge clk)
    if (resetN && idxValid && idxReady) seen.push_back(idxOut);

  task automatic load3(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    mem[0] = a; mem[1] = b; mem[2] = c;
    q_cnt = n; q_rd = 0; deq_count = 0;
    seen.delete();
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_seen(input string tag, input int idx, input logic [W-1:0] exp);
    if (idx < seen.size()) check_eq(tag, 32'(seen[idx]), 32'(exp));
    else                   check_eq({tag, "_missing"}, 32'(seen.size()), 32'(idx + 1));
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; idxReady = 1'b1; queueIndex = '0;
    #12;
    check_eq("rst_dequeue",  32'(dequeue),  32'd0);
    check_eq("rst_idxValid", 32'(idxValid), 32'd0);
    check_eq("rst_idxOut",   32'(idxOut),   32'd0);
    check_eq("rst_popCount", 32'(popCount), 32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_done",     32'(done),     32'd0);
    @(negedge clk) resetN = 1'b1;

    // Three-entry drain with exact latency
    load3(3, 10'd3, 10'd17, 10'd783);
    do_start();
    check_eq("lat_c1_busy", 32'(busy), 32'd1);
    check_eq("lat_c1_deq",  32'(dequeue), 32'd0);
    @(negedge clk) check_eq("lat_c2_deq", 32'(dequeue), 32'd1);
    @(negedge clk) check_eq("lat_c3_deq", 32'(dequeue), 32'd0);
    @(negedge clk) check_eq("lat_c4_valid", 32'(idxValid), 32'd0);
    @(negedge clk) begin
      check_eq("lat_c5_valid", 32'(idxValid), 32'd1);
      check_eq("lat_c5_idx",   32'(idxOut),   32'd3);
    end
    wait_done("drain3", 100);
    check_seen("drain3_idx0", 0, 10'd3);
    check_seen("drain3_idx1", 1, 10'd17);
    check_seen("drain3_idx2", 2, 10'd783);
    check_eq("drain3_deqs", deq_count, 32'd3);
    check_eq("drain3_pop",  32'(popCount), 32'd3);
    check_eq("drain3_busy", 32'(busy), 32'd0);

    // Empty queue: done in cycle 2, no pop
    load3(0, 10'd0, 10'd0, 10'd0);
    do_start();
    check_eq("empty_c1_done", 32'(done), 32'd0);
    check_eq("empty_c1_pop",  32'(popCount), 32'd0);
    @(negedge clk) check_eq("empty_c2_done", 32'(done), 32'd1);
    check_eq("empty_deqs", deq_count, 32'd0);
    check_eq("empty_pop",  32'(popCount), 32'd0);

    // Backpressure holds index and blocks further pops
    load3(2, 10'd5, 10'd6, 10'd0);
    idxReady = 1'b0;
    do_start();
    for (int i = 0; i < 20 && !idxValid; i++) @(negedge clk);
    check_eq("bp_valid", 32'(idxValid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold_idx",   32'(idxOut),   32'd5);
      check_eq("bp_hold_valid", 32'(idxValid), 32'd1);
      check_eq("bp_hold_deqs",  deq_count,     32'd1);
    end
    idxReady = 1'b1;
    wait_done("bp", 100);
    check_seen("bp_idx0", 0, 10'd5);
    check_seen("bp_idx1", 1, 10'd6);
    check_eq("bp_pop", 32'(popCount), 32'd2);

    // start during DEQ_LO is ignored
    load3(2, 10'd1, 10'd2, 10'd0);
    do_start();
    @(negedge clk);
    @(negedge clk) start = 1'b1;
    check_eq("ign_deq_lo", 32'(dequeue), 32'd0);
    @(negedge clk) start = 1'b0;
    check_eq("ign_busy", 32'(busy), 32'd1);
    wait_done("ign", 100);
    check_eq("ign_pop",  32'(popCount), 32'd2);
    check_eq("ign_deqs", deq_count, 32'd2);
    check_seen("ign_idx1", 1, 10'd2);

    // Reset during second DEQ_HI, then drain the remainder
    load3(3, 10'd10, 10'd20, 10'd30);
    do_start();
    for (int i = 0; i < 40 && !(dequeue && deq_count == 2); i++) @(negedge clk);
    check_eq("rst2_in_deq_hi", 32'(dequeue), 32'd1);
    #1 resetN = 1'b0;
    #1;
    check_eq("rst2_dequeue",  32'(dequeue),  32'd0);
    check_eq("rst2_idxValid", 32'(idxValid), 32'd0);
    check_eq("rst2_idxOut",   32'(idxOut),   32'd0);
    check_eq("rst2_popCount", 32'(popCount), 32'd0);
    check_eq("rst2_busy",     32'(busy),     32'd0);
    check_eq("rst2_done",     32'(done),     32'd0);
    @(negedge clk) resetN = 1'b1;
    do_start();
    wait_done("rst2", 100);
    check_eq("rst2_pop", 32'(popCount), 32'd1);
    check_seen("rst2_last", 1, 10'd30);

`ifdef INDEX_QUEUE_LIMIT_EN
    // Guard terminates a queue that never reports empty
    load3(0, 10'd0, 10'd0, 10'd0);
    stuck = 1'b1;
    do_start();
    check_eq("lim_clr", 32'(limitHit), 32'd0);
    wait_done("lim", 5000);
    check_eq("lim_deqs", deq_count, 32'd784);
    check_eq("lim_pop",  32'(popCount), 32'd784);
    check_eq("lim_done", 32'(done), 32'd1);
    check_eq("lim_hit",  32'(limitHit), 32'd1);
    stuck = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
